// File: rtl/audio_out_buffer_if.sv
// ----------------------------------------------------------------------------
// audio_out_buffer_if
// Purpose : Sample-path and codec write-port signals of the audio output buffer.
//   in_valid / in_left / in_right          : filtered L/R pair from the FIR stage
//   write_ready                            : codec can take a pair this cycle
//   write / writedata_left / writedata_right : pair offered to the codec
// Modports:
//   master : environment side (FIR filters + codec); drives inputs, observes outputs
//   slave  : audio_out_buffer side
// ----------------------------------------------------------------------------
interface audio_out_buffer_if #(
   parameter int unsigned W = 24
);

   logic         in_valid;
   logic [W-1:0] in_left;
   logic [W-1:0] in_right;
   logic         write_ready;
   logic         write;
   logic [W-1:0] writedata_left;
   logic [W-1:0] writedata_right;

   modport master (
      output in_valid,
      output in_left,
      output in_right,
      output write_ready,
      input  write,
      input  writedata_left,
      input  writedata_right
   );

   modport slave (
      input  in_valid,
      input  in_left,
      input  in_right,
      input  write_ready,
      output write,
      output writedata_left,
      output writedata_right
   );

endinterface

// File: rtl/audio_out_buffer.sv
// ----------------------------------------------------------------------------
// audio_out_buffer
// Purpose : Stereo L/R sample FIFO between the FIR filter outputs and the
//           audio codec write port. Absorbs the rate mismatch, counts dropped
//           pairs (overflow) and starved codec cycles (underrun).
// Parameters:
//   DEPTH : number of L/R pairs stored (power of 2, >= 2)
//   W     : sample width per channel (two's complement, passed bit-exact)
// Ports:
//   clk     : system clock, all state updates on posedge
//   reset   : synchronous, active-high
//   bus     : audio_out_buffer_if.slave (in_valid/in_left/in_right,
//             write_ready, write/writedata_left/writedata_right)
//   level   : pairs currently stored, 0..DEPTH
//   full    : level == DEPTH
//   empty   : level == 0
//   ovf_cnt : dropped-pair count, saturating
//   unf_cnt : underrun cycle count, saturating
// Configuration:
//   AOB_UNDERRUN_HOLD_EN : when defined, an empty FIFO with write_ready set
//                          repeats the last popped pair to the codec
//                          (write=1). When undefined, write=0 while empty.
// ----------------------------------------------------------------------------
module audio_out_buffer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   audio_out_buffer_if.slave          bus,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic [15:0]                ovf_cnt,
   output logic [15:0]                unf_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned CW = 16;

   logic [PW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [PW-1:0] last_pair;
   logic [PW-1:0] head_pair;

   logic push;
   logic pop;
   logic drop;
   logic underrun;

   // Status flags decoded from the level register
   always_comb begin
      full  = (level == LW'(DEPTH));
      empty = (level == LW'(0));
   end

   // Codec-side show-ahead output; an empty FIFO presents the last popped pair
   always_comb begin
      head_pair = mem[rd_ptr];
`ifdef AOB_UNDERRUN_HOLD_EN
      bus.write = !empty || bus.write_ready;
`else
      bus.write = !empty;
`endif
      if (empty) begin
         bus.writedata_left  = last_pair[PW-1:W];
         bus.writedata_right = last_pair[W-1:0];
      end else begin
         bus.writedata_left  = head_pair[PW-1:W];
         bus.writedata_right = head_pair[W-1:0];
      end
   end

   // Transfer qualifiers; a pair arriving while full only enters alongside a pop
   always_comb begin
      pop      = bus.write && bus.write_ready && !empty;
      push     = bus.in_valid && (!full || pop);
      drop     = bus.in_valid && full && !pop;
      underrun = empty && bus.write_ready;
   end

   // Pair storage, deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.in_left, bus.in_right};
      end
   end

   // Pointers, level, last popped pair and saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         last_pair <= '0;
         ovf_cnt   <= '0;
         unf_cnt   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            last_pair <= head_pair;
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
         if (drop && (ovf_cnt != {CW{1'b1}})) begin
            ovf_cnt <= ovf_cnt + CW'(1);
         end
         if (underrun && (unf_cnt != {CW{1'b1}})) begin
            unf_cnt <= unf_cnt + CW'(1);
         end
      end
   end

endmodule
